// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 scan-code decoder and key tracker.
package ps2_pkg;

  localparam int KEY_W = 9;

  localparam logic [7:0] PFX_EXT     = 8'hE0;
  localparam logic [7:0] PFX_BRK     = 8'hF0;
  localparam logic [7:0] PFX_PAUSE   = 8'hE1;
  localparam logic [7:0] BYTE_BAT    = 8'hAA;
  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;
  localparam logic [7:0] BYTE_NULL   = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } dec_state_t;

  // Controller housekeeping bytes that never carry a key code.
  function automatic logic is_housekeeping(input logic [7:0] b);
    return (b == BYTE_BAT) || (b == BYTE_ACK) || (b == BYTE_RESEND);
  endfunction

  // Bytes that may not terminate a break sequence.
  function automatic logic is_bad_break_byte(input logic [7:0] b);
    return (b == PFX_EXT) || (b == PFX_PAUSE) || (b == PFX_BRK) || (b == BYTE_NULL);
  endfunction

endpackage

// File: rtl/ps2_seq_decoder.sv
// Turns the PS/2 byte stream into completed {valid, is_break, ext, code}
// strobes (same cycle as the final byte) plus a registered error pulse.
module ps2_seq_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       data_en,
  output logic       valid,
  output logic       is_break,
  output logic       ext,
  output logic [7:0] code,
  output logic       seq_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  dec_state_t    state;
  dec_state_t    eff_state;
  logic [TW-1:0] tcount;
  logic [2:0]    skip;
  logic          timeout_now;
  logic          proto_err;
  logic          err_pend;
  logic          err_any;

  // A timeout in this cycle makes a coincident byte look as if it arrived in IDLE.
  assign timeout_now = (state != ST_IDLE) && (tcount == TW'(TIMEOUT_CYCLES - 1));
  assign eff_state   = timeout_now ? ST_IDLE : state;
  assign code        = data;
  assign err_any     = timeout_now | proto_err | err_pend;

  // Classify the incoming byte against the effective state.
  always_comb begin
    valid     = 1'b0;
    is_break  = 1'b0;
    ext       = 1'b0;
    proto_err = 1'b0;
    if (data_en) begin
      case (eff_state)
        ST_IDLE: begin
          if ((data != PFX_EXT) && (data != PFX_BRK) && (data != PFX_PAUSE) &&
              !is_housekeeping(data)) begin
            valid = 1'b1;
          end else begin
            valid = 1'b0;
          end
        end
        ST_EXT: begin
          if ((data == PFX_PAUSE) || (data == BYTE_NULL)) begin
            proto_err = 1'b1;
          end else if ((data != PFX_BRK) && (data != PFX_EXT)) begin
            valid = 1'b1;
            ext   = 1'b1;
          end else begin
            valid = 1'b0;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          if (is_bad_break_byte(data)) begin
            proto_err = 1'b1;
          end else begin
            valid    = 1'b1;
            is_break = 1'b1;
            ext      = (eff_state == ST_EXT_BRK);
          end
        end
        default: begin
          valid = 1'b0;
        end
      endcase
    end else begin
      valid = 1'b0;
    end
  end

  // Sequence FSM, timeout/skip counters and the error pulse, which is
  // deferred by a cycle if it would collide with a completed code.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      tcount    <= '0;
      skip      <= 3'd0;
      seq_error <= 1'b0;
      err_pend  <= 1'b0;
    end else begin
      seq_error <= err_any & ~valid;
      err_pend  <= err_any & valid;
      if (data_en) begin
        tcount <= '0;
        case (eff_state)
          ST_IDLE: begin
            skip <= (data == PFX_PAUSE) ? 3'd7 : 3'd0;
            if (data == PFX_EXT)        state <= ST_EXT;
            else if (data == PFX_BRK)   state <= ST_BRK;
            else if (data == PFX_PAUSE) state <= ST_PAUSE;
            else                        state <= ST_IDLE;
          end
          ST_EXT: begin
            if (data == PFX_BRK)      state <= ST_EXT_BRK;
            else if (data == PFX_EXT) state <= ST_EXT;
            else                      state <= ST_IDLE;
          end
          ST_PAUSE: begin
            if (skip <= 3'd1) begin
              state <= ST_IDLE;
              skip  <= 3'd0;
            end else begin
              skip <= skip - 3'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (timeout_now) begin
        state  <= ST_IDLE;
        skip   <= 3'd0;
        tcount <= TW'(TIMEOUT_CYCLES);
      end else if (state != ST_IDLE) begin
        tcount <= tcount + TW'(1);
      end else begin
        tcount <= tcount;
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Tracks held/toggled state of a configurable table of PS/2 keys and
// pulses make/break events for each tracked key.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int                          NUM_KEYS       = 8,
  parameter logic [NUM_KEYS*KEY_W-1:0]   KEY_CODES      = {NUM_KEYS{9'h000}},
  parameter int                          TIMEOUT_CYCLES = 50000,
  parameter int                          TOGGLE_MODE    = 0
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          received_data,
  input  logic                received_data_en,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_make,
  output logic [NUM_KEYS-1:0] key_break,
  output logic [KEY_W-1:0]    last_code,
  output logic                seq_error
);

  logic                dec_valid;
  logic                dec_break;
  logic                dec_ext;
  logic [7:0]          dec_code;
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] match;

  ps2_seq_decoder #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_dec (
    .clk      (CLOCK_50),
    .reset    (reset),
    .data     (received_data),
    .data_en  (received_data_en),
    .valid    (dec_valid),
    .is_break (dec_break),
    .ext      (dec_ext),
    .code     (dec_code),
    .seq_error(seq_error)
  );

  // Parallel compare of the completed code against every table entry.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      match[i] = (KEY_CODES[KEY_W*i +: KEY_W] == {dec_ext, dec_code});
    end
  end

  // Key table update; duplicate table entries move together.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_state <= '0;
      key_held  <= '0;
      key_make  <= '0;
      key_break <= '0;
      last_code <= 9'h000;
    end else begin
      key_make  <= '0;
      key_break <= '0;
      if (dec_valid) begin
        last_code <= {dec_ext, dec_code};
        for (int i = 0; i < NUM_KEYS; i++) begin
          if (match[i] && !dec_break && !key_held[i]) begin
            key_held[i]  <= 1'b1;
            key_make[i]  <= 1'b1;
            key_state[i] <= (TOGGLE_MODE != 0) ? ~key_state[i] : 1'b1;
          end else if (match[i] && dec_break && key_held[i]) begin
            key_held[i]  <= 1'b0;
            key_break[i] <= 1'b1;
            key_state[i] <= (TOGGLE_MODE != 0) ? key_state[i] : 1'b0;
          end else begin
            key_held[i] <= key_held[i];
          end
        end
      end else begin
        last_code <= last_code;
      end
    end
  end

endmodule
